sram_bist: RTL and testbench

SRAM_BIST -- requirements
Module: sram_bist

---
 rtl/sram_bist_if.sv | 32 +++
 rtl/sram_bist.sv | 146 ++++++++++++++
 tb/tb_sram_bist.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bist_if.sv
// Handshake and SRAM port bundle between the BIST engine and its surroundings.
interface sram_bist_if;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned CW = 4;

  logic          start;
  logic          busy;
  logic          done;
  logic          pass;
  logic [CW-1:0] err_count;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // BIST engine side
  modport master (
    input  start, mem_rdata,
    output busy, done, pass, err_count, fail_addr, fail_data,
           mem_we, mem_addr, mem_wdata
  );

  // Controller / SRAM side
  modport slave (
    output start, mem_rdata,
    input  busy, done, pass, err_count, fail_addr, fail_data,
           mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sram_bist.sv
// Two-background SRAM BIST: ascending write/read-check of PAT, then
// descending write/read-check of ~PAT, with saturating error count and
// first-failure capture.
module sram_bist #(
  parameter int unsigned DEPTH = 10,
  parameter logic [3:0]  PAT   = 4'hA
) (
  input  logic         clk,
  input  logic         rst_n,
  sram_bist_if.master  bif
);

  localparam int unsigned AW = 4;
  localparam int unsigned CW = 4;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] ERR_MAX   = '1;
  localparam logic [3:0]    PAT_N     = ~PAT;

  typedef enum logic [2:0] {
    IDLE, WR_A, RDI_A, RDC_A, WR_B, RDI_B, RDC_B, DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] addr;
  logic          mismatch_c;
  logic [CW-1:0] err_next_c;

  // Read-data check in the compare states and the saturated next error count
  always_comb begin
    mismatch_c = 1'b0;
    err_next_c = bif.err_count;
    if (state == RDC_A) begin
      mismatch_c = (bif.mem_rdata != PAT);
    end else if (state == RDC_B) begin
      mismatch_c = (bif.mem_rdata != PAT_N);
    end
    if (mismatch_c && (bif.err_count != ERR_MAX)) begin
      err_next_c = bif.err_count + CW'(1);
    end
  end

  // Sequencer with all outputs registered on the transition into each state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr          <= '0;
      bif.busy      <= 1'b0;
      bif.done      <= 1'b0;
      bif.pass      <= 1'b0;
      bif.err_count <= '0;
      bif.fail_addr <= '0;
      bif.fail_data <= '0;
      bif.mem_we    <= 1'b0;
      bif.mem_addr  <= '0;
      bif.mem_wdata <= '0;
    end else begin
      bif.done <= 1'b0;

      if (mismatch_c) begin
        bif.err_count <= err_next_c;
        if (bif.err_count == '0) begin
          bif.fail_addr <= addr;
          bif.fail_data <= bif.mem_rdata;
        end
      end

      case (state)
        IDLE: begin
          if (bif.start) begin
            state         <= WR_A;
            addr          <= '0;
            bif.err_count <= '0;
            bif.fail_addr <= '0;
            bif.fail_data <= '0;
            bif.pass      <= 1'b0;
            bif.busy      <= 1'b1;
            bif.mem_we    <= 1'b1;
            bif.mem_addr  <= '0;
            bif.mem_wdata <= PAT;
          end
        end

        WR_A: begin
          if (addr == LAST_ADDR) begin
            state        <= RDI_A;
            addr         <= '0;
            bif.mem_we   <= 1'b0;
            bif.mem_addr <= '0;
          end else begin
            addr         <= addr + AW'(1);
            bif.mem_addr <= addr + AW'(1);
          end
        end

        RDI_A: state <= RDC_A;

        RDC_A: begin
          if (addr == LAST_ADDR) begin
            state         <= WR_B;
            addr          <= LAST_ADDR;
            bif.mem_we    <= 1'b1;
            bif.mem_addr  <= LAST_ADDR;
            bif.mem_wdata <= PAT_N;
          end else begin
            state        <= RDI_A;
            addr         <= addr + AW'(1);
            bif.mem_addr <= addr + AW'(1);
          end
        end

        WR_B: begin
          if (addr == '0) begin
            state        <= RDI_B;
            addr         <= LAST_ADDR;
            bif.mem_we   <= 1'b0;
            bif.mem_addr <= LAST_ADDR;
          end else begin
            addr         <= addr - AW'(1);
            bif.mem_addr <= addr - AW'(1);
          end
        end

        RDI_B: state <= RDC_B;

        RDC_B: begin
          if (addr == '0) begin
            state        <= DONE;
            bif.busy     <= 1'b0;
            bif.done     <= 1'b1;
            bif.pass     <= (err_next_c == '0);
            bif.mem_addr <= '0;
          end else begin
            state        <= RDI_B;
            addr         <= addr - AW'(1);
            bif.mem_addr <= addr - AW'(1);
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bist.sv
// Bench for sram_bist: faulty SRAM model, cycle-indexed behavioural reference
// and directed scenarios with hand-computed results.
module tb_sram_bist;
  localparam int D   = 10;
  localparam int LAT = 6 * D;
  localparam logic [3:0] PAT   = 4'hA;
  localparam logic [3:0] PAT_N = 4'h5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_bist_if bif();

  sram_bist #(.DEPTH(D), .PAT(PAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bif   (bif)
  );

  int checks   = 0;
  int failures = 0;
  int mode     = 0;
  bit chk_en   = 1'b0;
  int done_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Fault injection on the read path
  function automatic logic [3:0] fault_read(input int m, input logic [3:0] a, input logic [3:0] v);
    logic [3:0] r;
    r = v;
    if (m == 1 && a == 4'd3) r[0] = 1'b0;
    if (m == 2) r[3] = 1'b1;
    if (m == 3) r = 4'h0;
    return r;
  endfunction

  // SRAM with registered read data
  logic [3:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 4'h0;
  always @(posedge clk) begin
    if (bif.mem_we) mem[bif.mem_addr] <= bif.mem_wdata;
    bif.mem_rdata <= fault_read(mode, bif.mem_addr, mem[bif.mem_addr]);
  end

  // Reference: t = cycle index within a pass (0 = idle, 1..LAT busy, LAT+1 done)
  int         m_t;
  logic       h_pass;
  logic [3:0] h_err, h_fa, h_fd;

  function automatic void model_bus(input int t, output logic we, output logic [3:0] a, output logic [3:0] wd);
    we = 1'b0; a = 4'h0; wd = 4'h0;
    if (t >= 1 && t <= D) begin
      we = 1'b1; a = 4'(t - 1); wd = PAT;
    end else if (t > D && t <= 3 * D) begin
      a = 4'((t - D - 1) / 2);
    end else if (t > 3 * D && t <= 4 * D) begin
      we = 1'b1; a = 4'(D - 1 - (t - 3 * D - 1)); wd = PAT_N;
    end else if (t > 4 * D && t <= 6 * D) begin
      a = 4'(D - 1 - (t - 4 * D - 1) / 2);
    end
  endfunction

  // Error tally from every compare whose result is visible by cycle t
  function automatic void model_res(input int t, input int m, output logic [3:0] e,
                                    output logic [3:0] fa, output logic [3:0] fd);
    int cnt;
    logic [3:0] a, ex, rv;
    int vis;
    cnt = 0; fa = 4'h0; fd = 4'h0;
    for (int k = 0; k < 2 * D; k++) begin
      if (k < D) begin
        a = 4'(k); ex = PAT; vis = D + 3 + 2 * k;
      end else begin
        a = 4'(D - 1 - (k - D)); ex = PAT_N; vis = 4 * D + 3 + 2 * (k - D);
      end
      if (t >= vis) begin
        rv = fault_read(m, a, ex);
        if (rv != ex) begin
          if (cnt == 0) begin fa = a; fd = rv; end
          cnt++;
        end
      end
    end
    e = (cnt > 15) ? 4'd15 : 4'(cnt);
  endfunction

  always @(posedge clk) begin
    logic [3:0] e, fa, fd;
    if (!rst_n) begin
      m_t <= 0; h_pass <= 1'b0; h_err <= 4'h0; h_fa <= 4'h0; h_fd <= 4'h0;
    end else if (m_t == 0) begin
      if (bif.start) m_t <= 1;
    end else if (m_t == LAT + 1) begin
      model_res(m_t, mode, e, fa, fd);
      m_t <= 0; h_err <= e; h_fa <= fa; h_fd <= fd; h_pass <= (e == 4'h0);
    end else begin
      m_t <= m_t + 1;
    end
  end

  // Per-cycle compare against the reference
  always @(negedge clk) begin
    logic we, pass_e;
    logic [3:0] a, wd, e, fa, fd;
    if (chk_en) begin
      model_bus(m_t, we, a, wd);
      if (m_t == 0) begin
        e = h_err; fa = h_fa; fd = h_fd; pass_e = h_pass;
      end else begin
        model_res(m_t, mode, e, fa, fd);
        pass_e = (m_t == LAT + 1) && (e == 4'h0);
      end
      chk("busy", int'(bif.busy), int'(m_t >= 1 && m_t <= LAT));
      chk("done", int'(bif.done), int'(m_t == LAT + 1));
      chk("pass", int'(bif.pass), int'(pass_e));
      chk("err_count", int'(bif.err_count), int'(e));
      chk("fail_addr", int'(bif.fail_addr), int'(fa));
      chk("fail_data", int'(bif.fail_data), int'(fd));
      chk("mem_we", int'(bif.mem_we), int'(we));
      chk("mem_addr", int'(bif.mem_addr), int'(a));
      if (we) chk("mem_wdata", int'(bif.mem_wdata), int'(wd));
      if (bif.done) done_cnt++;
    end
  end

  task automatic start_pulse();
    @(posedge clk); #2 bif.start = 1'b1;
    @(posedge clk); #2 bif.start = 1'b0;
  endtask

  task automatic wait_done(output int nbusy, output bit seen);
    nbusy = 0; seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bif.done) begin seen = 1'b1; break; end
      if (bif.busy) nbusy++;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_and_check(input string tag, input int exp_pass, input int exp_err,
                               input int exp_fa, input int exp_fd);
    int nb; bit seen;
    start_pulse();
    wait_done(nb, seen);
    chk({tag, "_done_seen"}, int'(seen), 1);
    chk({tag, "_busy_cycles"}, nb, LAT);
    chk({tag, "_pass"}, int'(bif.pass), exp_pass);
    chk({tag, "_err"}, int'(bif.err_count), exp_err);
    chk({tag, "_fail_addr"}, int'(bif.fail_addr), exp_fa);
    chk({tag, "_fail_data"}, int'(bif.fail_data), exp_fd);
    @(posedge clk); #1;
    chk({tag, "_pass_hold"}, int'(bif.pass), exp_pass);
    chk({tag, "_busy_after"}, int'(bif.busy), 0);
  endtask

  initial begin
    int nb, dc; bit seen;
    rst_n = 1'b0;
    bif.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_busy", int'(bif.busy), 0);
    chk("rst_err", int'(bif.err_count), 0);
    chk("rst_mem_we", int'(bif.mem_we), 0);
    repeat (2) @(posedge clk);

    mode = 0; run_and_check("clean", 1, 0, 0, 0);
    mode = 1; run_and_check("addr3_b0", 0, 1, 3, 4);
    mode = 2; run_and_check("b3_sa1", 0, 10, 9, 13);
    mode = 3; run_and_check("rd_zero", 0, 15, 0, 0);

    // start hammered while busy and during the done cycle
    mode = 0;
    dc = done_cnt;
    start_pulse();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2 bif.start = (i % 3 == 0);
    end
    bif.start = 1'b0;
    wait_done(nb, seen);
    chk("rep_done_seen", int'(seen), 1);
    #1 bif.start = 1'b1;
    @(posedge clk); #2 bif.start = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    chk("rep_done_count", done_cnt - dc, 1);
    chk("rep_idle_busy", int'(bif.busy), 0);
    chk("rep_pass", int'(bif.pass), 1);

    // reset in the middle of a pass with errors already counted
    mode = 3;
    dc = done_cnt;
    start_pulse();
    repeat (24) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", int'(bif.busy), 0);
    chk("abort_err", int'(bif.err_count), 0);
    chk("abort_mem_wdata", int'(bif.mem_wdata), 0);
    chk("abort_mem_addr", int'(bif.mem_addr), 0);
    #1 rst_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - dc, 0);
    mode = 0; run_and_check("after_abort", 1, 0, 0, 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
